// File: rtl/seq_countdown_timer.sv
// Minutes/seconds countdown timer: loads a clamped mm:ss value, decrements once per
// qualified tick, pulses done on reaching 00:00 and holds expired until the next load.
module seq_countdown_timer #(
   parameter int unsigned MAX_MINS = 59,
   parameter int unsigned MAX_SECS = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [5:0] load_mins,
   input  logic [5:0] load_secs,
   input  logic       tick,
   input  logic       run,
   output logic [5:0] mins,
   output logic [5:0] secs,
   output logic       done,
   output logic       expired
);

   localparam logic [5:0] MAX_M = 6'(MAX_MINS);
   localparam logic [5:0] MAX_S = 6'(MAX_SECS);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      EXPIRED = 2'b10
   } state_t;

   state_t     state, state_nx;
   logic [5:0] mins_nx, secs_nx;
   logic       done_nx, expired_nx;
   logic [5:0] clamp_m, clamp_s;
   logic       step;

   assign step = tick & run;

   always_comb begin
      clamp_m    = (load_mins > MAX_M) ? MAX_M : load_mins;
      clamp_s    = (load_secs > MAX_S) ? MAX_S : load_secs;
      state_nx   = state;
      mins_nx    = mins;
      secs_nx    = secs;
      done_nx    = 1'b0;
      expired_nx = expired;

      if (load) begin
         mins_nx    = clamp_m;
         secs_nx    = clamp_s;
         expired_nx = 1'b0;
         state_nx   = ((clamp_m != '0) || (clamp_s != '0)) ? ARMED : IDLE;
      end else begin
         case (state)
            IDLE: begin
               expired_nx = 1'b0;
            end
            ARMED: begin
               if ((mins == '0) && (secs == '0)) begin
                  // ARMED with a zero count cannot be reached legally; fall back to IDLE
                  state_nx   = IDLE;
                  expired_nx = 1'b0;
               end else if (step) begin
                  if (secs != '0) begin
                     secs_nx = secs - 6'd1;
                  end else begin
                     secs_nx = MAX_S;
                     mins_nx = mins - 6'd1;
                  end
                  if ((mins == '0) && (secs == 6'd1)) begin
                     state_nx   = EXPIRED;
                     done_nx    = 1'b1;
                     expired_nx = 1'b1;
                  end
               end
            end
            EXPIRED: begin
               expired_nx = 1'b1;
            end
            default: begin
               state_nx   = IDLE;
               mins_nx    = '0;
               secs_nx    = '0;
               expired_nx = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         mins    <= '0;
         secs    <= '0;
         done    <= 1'b0;
         expired <= 1'b0;
      end else begin
         state   <= state_nx;
         mins    <= mins_nx;
         secs    <= secs_nx;
         done    <= done_nx;
         expired <= expired_nx;
      end
   end

endmodule

// File: tb/tb_seq_countdown_timer.sv
// Scoreboarded bench for seq_countdown_timer: a total-seconds reference model predicts
// each cycle's outputs, a negedge monitor pops and compares them.
module tb_seq_countdown_timer;

   localparam int MAXM = 59;
   localparam int MAXS = 59;

   logic       clk;
   logic       reset;
   logic       load;
   logic [5:0] load_mins;
   logic [5:0] load_secs;
   logic       tick;
   logic       run;
   logic [5:0] mins;
   logic [5:0] secs;
   logic       done;
   logic       expired;

   seq_countdown_timer #(.MAX_MINS(MAXM), .MAX_SECS(MAXS)) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_mins (load_mins),
      .load_secs (load_secs),
      .tick      (tick),
      .run       (run),
      .mins      (mins),
      .secs      (secs),
      .done      (done),
      .expired   (expired)
   );

   typedef struct {
      int    m;
      int    s;
      bit    d;
      bit    e;
      string tag;
   } exp_t;

   exp_t  sbq[$];
   exp_t  mon_x;
   int    n_checks = 0;
   int    n_fail   = 0;
   int    rem      = 0;   // remaining time in seconds
   bit    m_exp    = 1'b0;
   string cur_tag  = "init";

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sbq.size());
      $fatal(1, "watchdog expired");
   end

   // Monitor: every cycle the DUT presents a registered result, compare against the queue head
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         mon_x = sbq.pop_front();
         n_checks++;
         if (mins !== 6'(mon_x.m) || secs !== 6'(mon_x.s) ||
             done !== mon_x.d || expired !== mon_x.e) begin
            n_fail++;
            $display("FAIL %s: got %0d:%0d done=%0b expired=%0b, expected %0d:%0d done=%0b expired=%0b",
                     mon_x.tag, mins, secs, done, expired, mon_x.m, mon_x.s, mon_x.d, mon_x.e);
         end
      end
   end

   task automatic check_now(input string tag, input int m, input int s, input bit d, input bit e);
      n_checks++;
      if (mins !== 6'(m) || secs !== 6'(s) || done !== d || expired !== e) begin
         n_fail++;
         $display("FAIL %s: got %0d:%0d done=%0b expired=%0b, expected %0d:%0d done=%0b expired=%0b",
                  tag, mins, secs, done, expired, m, s, d, e);
      end
   endtask

   task automatic step(input bit ld, input int lm, input int ls, input bit tk, input bit rn);
      exp_t x;
      bit   d;
      int   cm, cs;
      load      = ld;
      load_mins = 6'(lm);
      load_secs = 6'(ls);
      tick      = tk;
      run       = rn;
      @(posedge clk);
      d = 1'b0;
      if (ld) begin
         cm    = (lm > MAXM) ? MAXM : lm;
         cs    = (ls > MAXS) ? MAXS : ls;
         rem   = cm * (MAXS + 1) + cs;
         m_exp = 1'b0;
      end else if (tk && rn && rem > 0) begin
         rem = rem - 1;
         if (rem == 0) begin
            d     = 1'b1;
            m_exp = 1'b1;
         end
      end
      x.m   = rem / (MAXS + 1);
      x.s   = rem % (MAXS + 1);
      x.d   = d;
      x.e   = m_exp;
      x.tag = cur_tag;
      sbq.push_back(x);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      load      = 1'b0;
      load_mins = '0;
      load_secs = '0;
      tick      = 1'b0;
      run       = 1'b0;
      #3;
      check_now("reset_state", 0, 0, 1'b0, 1'b0);
      #4;
      reset = 1'b1;
      @(posedge clk);
      #1;

      cur_tag = "t1_short_count";
      step(1, 0, 3, 0, 0);
      repeat (4) step(0, 0, 0, 1, 1);

      cur_tag = "t2_borrow";
      step(1, 2, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1);

      cur_tag = "t3_qualify";
      step(1, 0, 5, 0, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0);

      cur_tag = "t4_full_range";
      step(1, 63, 63, 0, 0);
      repeat (3599) step(0, 0, 0, 1, 1);
      cur_tag = "t4_saturate";
      repeat (10) step(0, 0, 0, 1, 1);

      cur_tag = "t5_load_wins";
      step(1, 0, 10, 0, 0);
      repeat (3) step(0, 0, 0, 1, 1);
      step(1, 0, 7, 1, 1);
      step(0, 0, 0, 1, 1);
      cur_tag = "t5_load_zero";
      step(1, 0, 0, 1, 1);
      repeat (2) step(0, 0, 0, 1, 1);

      cur_tag = "t6_abort";
      step(1, 0, 2, 0, 0);
      step(0, 0, 0, 1, 1);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_now("t6_async_reset", 0, 0, 1'b0, 1'b0);
      rem   = 0;
      m_exp = 1'b0;
      #1;
      reset = 1'b1;
      cur_tag = "t6_after_release";
      repeat (4) step(0, 0, 0, 1, 1);

      cur_tag = "random";
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : 0,
              int'($urandom_range(0, 63)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0));
      end

      @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
